// File: rtl/disp_pkg.sv
// Shared constants and types for the seven-segment display refresh controller.
// Contents: blank/idle pin levels, the active-low hex-to-segment table and the
// 2-bit digit slot type.
package disp_pkg;

    // All segments off (active-low) and no anode selected (active-low).
    localparam logic [7:0] SEG_BLANK = 8'hFF;
    localparam logic [3:0] SEL_NONE  = 4'hF;

    // Digit slot index, 0 = rightmost digit.
    typedef logic [1:0] slot_t;

    // Segment pattern per hex value, bits [7:1] = a..g, bit 0 = dp (kept off).
    // Element [n] holds the pattern for nibble value n.
    localparam logic [15:0][7:0] SEG_TABLE = {
        8'h71,  // F
        8'h61,  // E
        8'h85,  // d
        8'h63,  // C
        8'hC1,  // b
        8'h11,  // A
        8'h09,  // 9
        8'h01,  // 8
        8'h1F,  // 7
        8'h41,  // 6
        8'h49,  // 5
        8'h99,  // 4
        8'h0D,  // 3
        8'h25,  // 2
        8'h9F,  // 1
        8'h03   // 0
    };

endpackage

// File: rtl/hex7seg.sv
// Combinational hex nibble to active-low seven-segment decoder.
// Ports:
//   nib_i  - 4-bit hex value
//   seg_o  - segments, active-low, [7:1] = a..g, [0] = dp (always 1)
module hex7seg
    import disp_pkg::*;
(
    input  logic [3:0] nib_i,
    output logic [7:0] seg_o
);

    assign seg_o = SEG_TABLE[nib_i];

endmodule

// File: rtl/disp_scan_ctrl.sv
// Refresh controller for a 4-digit multiplexed seven-segment display.
// A 16-bit value arrives over valid/ready into a pending buffer and is moved
// into the displayed (active) register only at a frame boundary, so a frame
// never mixes digits of two values. Each digit slot lasts DIV cycles and
// starts with BLANK cycles of anode-off dead time.
// Ports:
//   clk, rst    - clock, asynchronous active-high reset
//   in_valid    - requester offers in_data
//   in_ready    - pending buffer empty; transfer on in_valid && in_ready
//   in_data     - hex value, nibble 0 = rightmost digit
//   lz_en       - leading-zero suppression enable
//   outDisp     - segments, active-low, [7:1] = a..g, [0] = dp
//   selDisp     - digit anodes, active-low, bit k = digit k
//   frame_done  - one-cycle pulse at the start of each frame
module disp_scan_ctrl
    import disp_pkg::*;
#(
    parameter int unsigned DIV   = 50000,
    parameter int unsigned BLANK = 4
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [15:0] in_data,
    input  logic        lz_en,
    output logic [7:0]  outDisp,
    output logic [3:0]  selDisp,
    output logic        frame_done
);

    localparam int unsigned     CNT_W     = (DIV > 1) ? $clog2(DIV) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST  = CNT_W'(DIV - 1);
    localparam logic [CNT_W-1:0] CNT_BLANK = CNT_W'(BLANK);

    logic [CNT_W-1:0] cnt_q, cnt_d;
    slot_t            idx_q, idx_d;
    logic [15:0]      act_q, act_d;
    logic [15:0]      pend_q, pend_d;
    logic             pend_full_q, pend_full_d;
    logic [7:0]       seg_q, seg_d;
    logic [3:0]       sel_q, sel_d;
    logic             fd_q, fd_d;

    logic             cnt_last;
    logic             boundary;
    logic             xfer;
    logic [3:0]       nib;
    logic             lz_hide;
    logic             dead;

    // Ready drops with reset so nothing can be accepted while it is held.
    assign in_ready = ~pend_full_q & ~rst;

    // Digit decoder for the current slot's nibble.
    assign nib = act_q[{idx_q, 2'b00} +: 4];

    hex7seg u_hex7seg (
        .nib_i (nib),
        .seg_o (seg_d)
    );

    // Slot timing and pending/active buffer update.
    always_comb begin
        cnt_d       = cnt_q;
        idx_d       = idx_q;
        act_d       = act_q;
        pend_d      = pend_q;
        pend_full_d = pend_full_q;

        cnt_last = (cnt_q == CNT_LAST);
        boundary = cnt_last && (idx_q == 2'd3);
        xfer     = in_valid && in_ready;

        cnt_d = cnt_last ? '0 : cnt_q + CNT_W'(1);
        if (cnt_last) begin
            idx_d = idx_q + 2'd1;
        end

        if (xfer) begin
            pend_d      = in_data;
            pend_full_d = 1'b1;
        end
        // A transfer cannot coincide with this: in_ready is low while full.
        if (boundary && pend_full_q) begin
            act_d       = pend_q;
            pend_full_d = 1'b0;
        end
    end

    // Anode selection: dead time at slot start, optional leading-zero hide.
    always_comb begin
        lz_hide = 1'b0;
        case (idx_q)
            2'd1:    lz_hide = (act_q[15:4]  == 12'h000);
            2'd2:    lz_hide = (act_q[15:8]  == 8'h00);
            2'd3:    lz_hide = (act_q[15:12] == 4'h0);
            default: lz_hide = 1'b0;
        endcase

        dead  = (cnt_q < CNT_BLANK);
        sel_d = (dead || (lz_en && lz_hide)) ? SEL_NONE : ~(4'b0001 << idx_q);
        fd_d  = boundary;
    end

    // State and output registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_q       <= '0;
            idx_q       <= '0;
            act_q       <= '0;
            pend_q      <= '0;
            pend_full_q <= 1'b0;
            seg_q       <= SEG_BLANK;
            sel_q       <= SEL_NONE;
            fd_q        <= 1'b0;
        end else begin
            cnt_q       <= cnt_d;
            idx_q       <= idx_d;
            act_q       <= act_d;
            pend_q      <= pend_d;
            pend_full_q <= pend_full_d;
            seg_q       <= seg_d;
            sel_q       <= sel_d;
            fd_q        <= fd_d;
        end
    end

    assign outDisp    = seg_q;
    assign selDisp    = sel_q;
    assign frame_done = fd_q;

endmodule
